sec_scrub_injector: RTL and testbench

//  Generates custom-0 security instructions (CLRMEM, then CLRREG per register) on a scrub request.

---
 rtl/harvos_pkg.sv | 28 ++
 rtl/sec_lowest_set.sv | 25 ++
 rtl/sec_scrub_injector.sv | 120 ++++++++++++
 tb/tb_sec_scrub_injector.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/harvos_pkg.sv
// rtl/harvos_pkg.sv - custom-0 security opcode constants and scrub FSM state encoding
package harvos_pkg;

    localparam logic [6:0] OPCODE_SEC    = 7'b0001011;
    localparam logic [2:0] FUNCT3_CLRREG = 3'b000;
    localparam logic [2:0] FUNCT3_CLRMEM = 3'b001;

    typedef enum logic [1:0] {
        SCRUB_IDLE = 2'd0,
        SCRUB_MEM  = 2'd1,
        SCRUB_REGS = 2'd2,
        SCRUB_FIN  = 2'd3
    } scrub_state_e;

    localparam logic [1:0] ST_IDLE = 2'(SCRUB_IDLE);
    localparam logic [1:0] ST_MEM  = 2'(SCRUB_MEM);
    localparam logic [1:0] ST_REGS = 2'(SCRUB_REGS);
    localparam logic [1:0] ST_FIN  = 2'(SCRUB_FIN);

    function automatic logic [31:0] enc_clrreg(input logic [4:0] rd);
        return {12'b0, 5'b0, FUNCT3_CLRREG, rd, OPCODE_SEC};
    endfunction

    function automatic logic [31:0] enc_clrmem(input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, FUNCT3_CLRMEM, 5'b0, OPCODE_SEC};
    endfunction

endpackage

// File: rtl/sec_lowest_set.sv
// rtl/sec_lowest_set.sv - lowest-set-bit priority encoder with one-hot, index and any-set outputs
module sec_lowest_set #(
    parameter int W  = 32,
    parameter int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  vec,
    output logic [W-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Two's-complement trick isolates the lowest set bit.
    assign onehot = vec & (~vec + W'(1));
    assign any    = |vec;

    always_comb begin
        idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/sec_scrub_injector.sv
// rtl/sec_scrub_injector.sv - emits CLRMEM then CLRREG words as a valid/ready stream on a scrub request
module sec_scrub_injector
    import harvos_pkg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter int LAST_FLAG = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_mem,
    input  logic [4:0]  req_base_reg,
    input  logic [4:0]  req_len_reg,
    input  logic [31:0] req_keep_mask,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    localparam int   IW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic LAST_EN = (LAST_FLAG != 0);

    logic [1:0]          state;
    logic [NUM_REGS-1:0] rest;
    logic [NUM_REGS-1:0] req_pend;
    logic [NUM_REGS-1:0] enc_in;
    logic [NUM_REGS-1:0] enc_onehot;
    logic [NUM_REGS-1:0] enc_after;
    logic [IW-1:0]       enc_idx;
    logic                enc_any;
    logic [4:0]          enc_rd;
    logic                last_q;

    // x0 is never a candidate regardless of the keep mask.
    assign req_pend = ~req_keep_mask[NUM_REGS-1:0] & {{(NUM_REGS-1){1'b1}}, 1'b0};

    // In IDLE the encoder looks at the incoming request; otherwise at the
    // registers still owed, so the next rd is ready in the accepting cycle.
    assign enc_in    = (state == ST_IDLE) ? req_pend : rest;
    assign enc_after = enc_in & ~enc_onehot;
    assign enc_rd    = 5'(enc_idx);

    sec_lowest_set #(
        .W  (NUM_REGS),
        .IW (IW)
    ) u_lowest (
        .vec    (enc_in),
        .onehot (enc_onehot),
        .idx    (enc_idx),
        .any    (enc_any)
    );

    assign out_last = last_q & LAST_EN;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rest      <= '0;
            out_valid <= 1'b0;
            out_instr <= '0;
            last_q    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            done <= 1'b0;
            // req_ready reopens the cycle after the done pulse.
            if (done) begin
                req_ready <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (req_mem) begin
                            state     <= ST_MEM;
                            out_valid <= 1'b1;
                            out_instr <= enc_clrmem(req_base_reg, req_len_reg);
                            last_q    <= !enc_any;
                            rest      <= req_pend;
                        end else if (enc_any) begin
                            state     <= ST_REGS;
                            out_valid <= 1'b1;
                            out_instr <= enc_clrreg(enc_rd);
                            last_q    <= (enc_after == '0);
                            rest      <= enc_after;
                        end else begin
                            state <= ST_FIN;
                        end
                    end
                end
                ST_MEM, ST_REGS: begin
                    if (out_ready) begin
                        if (enc_any) begin
                            state     <= ST_REGS;
                            out_instr <= enc_clrreg(enc_rd);
                            last_q    <= (enc_after == '0);
                            rest      <= enc_after;
                        end else begin
                            state     <= ST_FIN;
                            out_valid <= 1'b0;
                            last_q    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sec_scrub_injector.sv
// tb/tb_sec_scrub_injector.sv - directed self-checking bench for sec_scrub_injector
module tb_sec_scrub_injector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_mem;
    logic [4:0]  req_base_reg;
    logic [4:0]  req_len_reg;
    logic [31:0] req_keep_mask;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_last;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    sec_scrub_injector #(.NUM_REGS(32), .LAST_FLAG(1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_mem       (req_mem),
        .req_base_reg  (req_base_reg),
        .req_len_reg   (req_len_reg),
        .req_keep_mask (req_keep_mask),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_last      (out_last),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // Issue one request at a negedge; returns at the negedge after acceptance.
    task automatic issue(input logic mem, input logic [4:0] base, input logic [4:0] len,
                         input logic [31:0] mask);
        req_valid     = 1'b1;
        req_mem       = mem;
        req_base_reg  = base;
        req_len_reg   = len;
        req_keep_mask = mask;
        @(negedge clk);
        req_valid     = 1'b0;
        req_mem       = 1'b0;
        req_base_reg  = 5'd0;
        req_len_reg   = 5'd0;
        req_keep_mask = 32'h0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s: done not seen within 100 cycles", name);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b0; req_mem = 1'b0; req_base_reg = 5'd0; req_len_reg = 5'd0;
        req_keep_mask = 32'h0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, out_instr, out_last, busy, done, req_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_values: got v=%b i=%h l=%b b=%b d=%b r=%b", out_valid, out_instr,
                     out_last, busy, done, req_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mem_only();
        out_ready = 1'b1;
        issue(1'b1, 5'd10, 5'd11, 32'hFFFF_FFFF);
        checks++;
        if ({out_valid, out_instr, out_last, busy, req_ready} !== {1'b1, 32'h00B5_100B, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL mem_word: got v=%b i=%h l=%b b=%b r=%b want 1 00b5100b 1 1 0",
                     out_valid, out_instr, out_last, busy, req_ready);
        end
        @(negedge clk);
        checks++;
        if ({out_valid, done, busy} !== 3'b001) begin
            errors++;
            $display("FAIL mem_fin: got v=%b d=%b b=%b want 0 0 1", out_valid, done, busy);
        end
        @(negedge clk);
        checks++;
        if ({done, busy, req_ready} !== 3'b100) begin
            errors++;
            $display("FAIL mem_done: got d=%b b=%b r=%b want 1 0 0", done, busy, req_ready);
        end
        @(negedge clk);
        checks++;
        if ({done, req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL mem_ready_back: got d=%b r=%b want 0 1", done, req_ready);
        end
    endtask

    task automatic test_single_reg();
        out_ready = 1'b1;
        issue(1'b0, 5'd0, 5'd0, ~(32'h1 << 5));
        checks++;
        if ({out_valid, out_instr, out_last} !== {1'b1, 32'h0000_028B, 1'b1}) begin
            errors++;
            $display("FAIL single_reg: got v=%b i=%h l=%b want 1 0000028b 1", out_valid, out_instr, out_last);
        end
        wait_done("single_reg_done");
    endtask

    task automatic test_all_regs();
        logic [31:0] exp;
        logic        is_clrreg;
        out_ready = 1'b1;
        issue(1'b0, 5'd0, 5'd0, 32'h0);
        for (int k = 1; k <= 31; k++) begin
            exp = (32'(k) << 7) | 32'h0000_000B;
            is_clrreg = (out_instr[6:0] == 7'b0001011) && (out_instr[14:12] == 3'b000) &&
                        (out_instr[31:15] == 17'h0);
            checks++;
            if ({out_valid, out_instr, out_last, is_clrreg} !== {1'b1, exp, (k == 31), 1'b1}) begin
                errors++;
                $display("FAIL all_regs_word%0d: got v=%b i=%h l=%b dec=%b want 1 %h %b 1",
                         k, out_valid, out_instr, out_last, is_clrreg, exp, (k == 31));
            end
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL all_regs_extra: out_valid=%b after word 31", out_valid);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL all_regs_done: done=%b want 1", done);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_stall();
        int          next_rd = 8;
        logic        held_valid = 1'b0;
        logic [31:0] held = 32'h0;
        int          stalls = 0;
        int          cyc = 0;
        out_ready = 1'b0;
        issue(1'b0, 5'd0, 5'd0, 32'hFFFF_00FF);
        while (next_rd <= 15 && cyc < 400) begin
            if (held_valid) begin
                checks++;
                if (out_valid !== 1'b1 || out_instr !== held) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b i=%h want 1 %h", out_valid, out_instr, held);
                end
            end
            out_ready = (cyc < 2) ? 1'b0 : 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                checks++;
                if (out_instr !== ((32'(next_rd) << 7) | 32'hB) || out_last !== (next_rd == 15)) begin
                    errors++;
                    $display("FAIL stall_seq: got i=%h l=%b want rd=%0d", out_instr, out_last, next_rd);
                end
                next_rd++;
                held_valid = 1'b0;
            end else begin
                held_valid = out_valid;
                held = out_instr;
                if (out_valid) stalls++;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b1;
        checks++;
        if (next_rd != 16 || stalls == 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_count: got next_rd=%0d stalls=%0d v=%b want 16 >0 0", next_rd, stalls, out_valid);
        end
        wait_done("stall_done");
    endtask

    task automatic test_empty();
        out_ready = 1'b1;
        issue(1'b0, 5'd3, 5'd4, 32'hFFFF_FFFF);
        checks++;
        if ({out_valid, done, busy, req_ready} !== 4'b0010) begin
            errors++;
            $display("FAIL empty_c1: got v=%b d=%b b=%b r=%b want 0 0 1 0", out_valid, done, busy, req_ready);
        end
        @(negedge clk);
        checks++;
        if ({out_valid, done, busy, req_ready} !== 4'b0100) begin
            errors++;
            $display("FAIL empty_c2: got v=%b d=%b b=%b r=%b want 0 1 0 0", out_valid, done, busy, req_ready);
        end
        @(negedge clk);
        checks++;
        if ({done, req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL empty_c3: got d=%b r=%b want 0 1", done, req_ready);
        end
        issue(1'b0, 5'd0, 5'd0, ~(32'h1 << 3));
        checks++;
        if ({out_valid, out_instr, out_last} !== {1'b1, 32'h0000_018B, 1'b1}) begin
            errors++;
            $display("FAIL empty_second: got v=%b i=%h l=%b want 1 0000018b 1", out_valid, out_instr, out_last);
        end
        wait_done("empty_second_done");
    endtask

    task automatic test_reset_mid();
        int seen_done = 0;
        out_ready = 1'b1;
        issue(1'b1, 5'd0, 5'd0, 32'h0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_instr, out_last, busy, done, req_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid_async: got v=%b i=%h l=%b b=%b d=%b r=%b", out_valid, out_instr,
                     out_last, busy, done, req_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || out_valid) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: %0d cycles with done/out_valid after reset, want 0", seen_done);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_mem_only();
        test_single_reg();
        test_all_regs();
        test_stall();
        test_empty();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
